regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback_if.sv | 11 +
 rtl/regfile_writeback.sv | 106 ++++++++++
 tb/tb_regfile_writeback.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// Producer-side result handshake into the writeback block.
// The producer holds in_valid/in_reg/in_data; the block answers with in_ready.
interface regfile_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_reg;
  logic [15:0] in_data;

  modport master (output in_valid, output in_reg, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_reg, input  in_data, output in_ready);
endinterface

// File: rtl/regfile_writeback.sv
// Register-file writeback stage: 4-deep result FIFO drained one entry per cycle,
// plus PC-increment arbitration where a write to register 7 takes priority.
module regfile_writeback (
  input  logic               clock,
  input  logic               reset,
  regfile_writeback_if.slave in_if,
  input  logic               pc_step,
  output logic [2:0]         WriteReg,
  output logic [15:0]        WriteData,
  output logic               RegWrite,
  output logic               incr_pc,
  output logic [7:0]         busy,
  output logic [2:0]         count,
  output logic               pc_overrun
);
  localparam logic [2:0] DEPTH = 3'd4;

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] data;
  } entry_t;

  entry_t      fifo_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic        reg_write_q;
  logic [2:0]  write_reg_q;
  logic [15:0] write_data_q;
  logic        incr_pc_q;
  logic        pc_pending_q, pc_pending_d;
  logic        pc_overrun_q, pc_overrun_d;
  logic        push, pop, load_r7, issue_pc;
  entry_t      head;
  logic [7:0]  busy_c;
  logic [1:0]  slot_offs;

  // Ready depends only on registered occupancy and reset, never on in_valid.
  assign in_if.in_ready = ~reset & (count_q != DEPTH);
  assign push           = in_if.in_valid & in_if.in_ready;

  always_comb begin
    head         = fifo_q[rd_ptr_q];
    pop          = (count_q != 3'd0);
    load_r7      = pop & (head.rd == 3'd7);
    issue_pc     = pc_pending_q & ~load_r7;
    // A new step always (re)arms the request, even on the edge that issues.
    pc_pending_d = pc_step | (pc_pending_q & ~issue_pc);
    pc_overrun_d = pc_overrun_q | (pc_step & pc_pending_q & ~issue_pc);
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      incr_pc_q    <= 1'b0;
      pc_pending_q <= 1'b0;
      pc_overrun_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      reg_write_q  <= pop;
      incr_pc_q    <= issue_pc;
      pc_pending_q <= pc_pending_d;
      pc_overrun_q <= pc_overrun_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + 2'd1;
        write_reg_q  <= head.rd;
        write_data_q <= head.data;
      end
    end
  end

  // NOTE: FIFO storage is not reset; an entry is only meaningful while count covers its slot.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= {in_if.in_reg, in_if.in_data};
  end

  // NOTE: busy_c gets a default before the loop so no latch is inferred.
  always_comb begin
    busy_c    = '0;
    slot_offs = '0;
    for (int i = 0; i < 4; i++) begin
      slot_offs = 2'(i) - rd_ptr_q;
      if ({1'b0, slot_offs} < count_q) busy_c[fifo_q[i].rd] = 1'b1;
    end
    if (reg_write_q) busy_c[write_reg_q] = 1'b1;
  end

  assign WriteReg   = write_reg_q;
  assign WriteData  = write_data_q;
  assign RegWrite   = reg_write_q;
  assign incr_pc    = incr_pc_q;
  assign busy       = busy_c;
  assign count      = count_q;
  assign pc_overrun = pc_overrun_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: FIFO ordering, PC arbitration, async reset.
// Inputs change 1 time unit after a rising edge; outputs are checked at that moment.
module tb_regfile_writeback;
  logic        clock;
  logic        reset;
  logic        pc_step;
  logic [2:0]  WriteReg;
  logic [15:0] WriteData;
  logic        RegWrite;
  logic        incr_pc;
  logic [7:0]  busy;
  logic [2:0]  count;
  logic        pc_overrun;

  int vectors    = 0;
  int miscompares = 0;

  regfile_writeback_if wb_if ();

  regfile_writeback dut (
    .clock      (clock),
    .reset      (reset),
    .in_if      (wb_if.slave),
    .pc_step    (pc_step),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .RegWrite   (RegWrite),
    .incr_pc    (incr_pc),
    .busy       (busy),
    .count      (count),
    .pc_overrun (pc_overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    pc_step        = 1'b0;
    wb_if.in_valid = 1'b0;
    wb_if.in_reg   = '0;
    wb_if.in_data  = '0;

    // Reset state
    #2;
    check("rst_count",     32'(count),          32'd0);
    check("rst_in_ready",  32'(wb_if.in_ready), 32'd0);
    check("rst_regwrite",  32'(RegWrite),       32'd0);
    check("rst_writereg",  32'(WriteReg),       32'd0);
    check("rst_writedata", 32'(WriteData),      32'd0);
    check("rst_incr_pc",   32'(incr_pc),        32'd0);
    check("rst_overrun",   32'(pc_overrun),     32'd0);
    check("rst_busy",      32'(busy),           32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(wb_if.in_ready), 32'd1);

    // Single push of {3, 0x1234}
    wb_if.in_valid = 1'b1;
    wb_if.in_reg   = 3'd3;
    wb_if.in_data  = 16'h1234;
    step();
    wb_if.in_valid = 1'b0;
    wb_if.in_reg   = 3'd6;
    wb_if.in_data  = 16'hDEAD;
    check("single_count_n",  32'(count),    32'd1);
    check("single_rw_n",     32'(RegWrite), 32'd0);
    check("single_busy_n",   32'(busy),     32'h08);
    step();
    check("single_rw_n1",    32'(RegWrite),  32'd1);
    check("single_wreg_n1",  32'(WriteReg),  32'd3);
    check("single_wdata_n1", 32'(WriteData), 32'h1234);
    check("single_busy_n1",  32'(busy),      32'h08);
    check("single_count_n1", 32'(count),     32'd0);
    step();
    check("single_rw_n2",    32'(RegWrite),  32'd0);
    check("single_hold_n2",  32'(WriteData), 32'h1234);
    check("single_hreg_n2",  32'(WriteReg),  32'd3);
    check("single_busy_n2",  32'(busy),      32'h00);

    // Five back-to-back pushes: drained one per cycle, in order
    for (int k = 0; k < 5; k++) begin
      wb_if.in_valid = 1'b1;
      wb_if.in_reg   = 3'(k);
      wb_if.in_data  = 16'hA000 + 16'(k);
      check("burst_ready", 32'(wb_if.in_ready), 32'd1);
      step();
      check("burst_count", 32'(count), 32'd1);
      if (k > 0) begin
        check("burst_rw",    32'(RegWrite),  32'd1);
        check("burst_wreg",  32'(WriteReg),  32'(k - 1));
        check("burst_wdata", 32'(WriteData), 32'h0000A000 + 32'(k - 1));
      end
    end
    wb_if.in_valid = 1'b0;
    step();
    check("burst_last_wreg",  32'(WriteReg),  32'd4);
    check("burst_last_wdata", 32'(WriteData), 32'hA004);
    check("burst_drained",    32'(count),     32'd0);
    step();
    check("burst_idle_rw",    32'(RegWrite),  32'd0);

    // pc_step with empty FIFO
    pc_step = 1'b1;
    step();
    pc_step = 1'b0;
    check("pc_empty_e",  32'(incr_pc), 32'd0);
    step();
    check("pc_empty_e1", 32'(incr_pc), 32'd1);
    step();
    check("pc_empty_e2", 32'(incr_pc), 32'd0);
    check("pc_empty_ov", 32'(pc_overrun), 32'd0);

    // pc_step coincident with a popped reg-7 write
    wb_if.in_valid = 1'b1;
    wb_if.in_reg   = 3'd7;
    wb_if.in_data  = 16'h0040;
    step();
    wb_if.in_valid = 1'b0;
    check("r7_busy", 32'(busy), 32'h80);
    pc_step = 1'b1;
    step();
    pc_step = 1'b0;
    check("r7_rw",     32'(RegWrite),  32'd1);
    check("r7_wreg",   32'(WriteReg),  32'd7);
    check("r7_wdata",  32'(WriteData), 32'h0040);
    check("r7_incr_0", 32'(incr_pc),   32'd0);
    step();
    check("r7_incr_1", 32'(incr_pc),    32'd1);
    check("r7_rw_off", 32'(RegWrite),   32'd0);
    check("r7_ov",     32'(pc_overrun), 32'd0);
    step();
    check("r7_incr_2", 32'(incr_pc),    32'd0);

    // pc_step on the same edge that issues: request stays armed
    pc_step = 1'b1;
    step();
    check("same_e0", 32'(incr_pc), 32'd0);
    step();
    pc_step = 1'b0;
    check("same_e1",    32'(incr_pc),    32'd1);
    check("same_e1_ov", 32'(pc_overrun), 32'd0);
    step();
    check("same_e2", 32'(incr_pc), 32'd1);
    step();
    check("same_e3", 32'(incr_pc), 32'd0);

    // Two pc_step pulses while reg-7 writes keep suppressing the increment
    wb_if.in_valid = 1'b1;
    wb_if.in_reg   = 3'd7;
    wb_if.in_data  = 16'h7001;
    pc_step        = 1'b1;
    step();
    wb_if.in_data  = 16'h7002;
    pc_step        = 1'b0;
    check("ovr_b0_incr", 32'(incr_pc), 32'd0);
    step();
    wb_if.in_data  = 16'h7003;
    pc_step        = 1'b1;
    check("ovr_b1_incr", 32'(incr_pc),    32'd0);
    check("ovr_b1_ov",   32'(pc_overrun), 32'd0);
    check("ovr_b1_wreg", 32'(WriteReg),   32'd7);
    step();
    wb_if.in_valid = 1'b0;
    pc_step        = 1'b0;
    check("ovr_b2_ov",   32'(pc_overrun), 32'd1);
    check("ovr_b2_incr", 32'(incr_pc),    32'd0);
    step();
    check("ovr_b3_incr",  32'(incr_pc),   32'd0);
    check("ovr_b3_wdata", 32'(WriteData), 32'h7003);
    step();
    check("ovr_b4_incr", 32'(incr_pc),  32'd1);
    check("ovr_b4_rw",   32'(RegWrite), 32'd0);
    step();
    check("ovr_b5_incr",   32'(incr_pc),    32'd0);
    check("ovr_b5_sticky", 32'(pc_overrun), 32'd1);
    repeat (3) step();
    check("ovr_sticky_later", 32'(pc_overrun), 32'd1);

    // Asynchronous reset mid-cycle with a queued entry and a pending PC request
    wb_if.in_valid = 1'b1;
    wb_if.in_reg   = 3'd5;
    wb_if.in_data  = 16'h5555;
    step();
    wb_if.in_reg   = 3'd6;
    wb_if.in_data  = 16'h6666;
    pc_step        = 1'b1;
    step();
    wb_if.in_valid = 1'b0;
    pc_step        = 1'b0;
    check("ar_pre_rw",    32'(RegWrite), 32'd1);
    check("ar_pre_count", 32'(count),    32'd1);
    check("ar_pre_busy",  32'(busy),     32'h60);
    #2;
    reset = 1'b1;
    #1;
    check("ar_count",    32'(count),          32'd0);
    check("ar_rw",       32'(RegWrite),       32'd0);
    check("ar_wreg",     32'(WriteReg),       32'd0);
    check("ar_wdata",    32'(WriteData),      32'd0);
    check("ar_busy",     32'(busy),           32'd0);
    check("ar_in_ready", 32'(wb_if.in_ready), 32'd0);
    check("ar_ov",       32'(pc_overrun),     32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("ar_ready_after", 32'(wb_if.in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("ar_no_rw",   32'(RegWrite), 32'd0);
      check("ar_no_incr", 32'(incr_pc),  32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no completion expected finish before 20000");
    $fatal(1, "bench timeout");
  end
endmodule
